// File: rtl/rv32e_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32e_alu_issue_if
// Purpose  : Handshake and operand bus between the issue stage and its
//            upstream decode slot / downstream ALU-writeback consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32e_alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        out_is_branch;
    logic [31:0] out_br_target;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, out_alu_op, out_a, out_b, out_rd, out_we,
               out_is_branch, out_br_target, out_pc, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, out_alu_op, out_a, out_b, out_rd, out_we,
               out_is_branch, out_br_target, out_pc, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/rv32e_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : rv32e_alu_issue
// Purpose  : RV32E ALU issue stage - decodes OP/OP-IMM/LUI/AUIPC/BRANCH into
//            ALU op + operands behind a registered 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rv32e_alu_issue #(
    parameter bit SKID_EN = 1'b1
) (
    input wire clk,
    input wire rst_n,
    rv32e_alu_issue_if.slave bus
);
    localparam logic [6:0] c_opc_op    = 7'b0110011;
    localparam logic [6:0] c_opc_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_lui   = 7'b0110111;
    localparam logic [6:0] c_opc_auipc = 7'b0010111;
    localparam logic [6:0] c_opc_br    = 7'b1100011;
    localparam logic [6:0] c_f7_zero   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_sll  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_slt  = 4'd8;
    localparam logic [3:0] c_alu_sltu = 4'd9;
    localparam logic [3:0] c_alu_seq  = 4'd10;
    localparam logic [3:0] c_alu_sne  = 4'd11;
    localparam logic [3:0] c_alu_sge  = 4'd12;
    localparam logic [3:0] c_alu_sgeu = 4'd13;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        we;
        logic        is_branch;
        logic [31:0] br_target;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return c_alu_add;
            3'b001:  return c_alu_sll;
            3'b010:  return c_alu_slt;
            3'b011:  return c_alu_sltu;
            3'b100:  return c_alu_xor;
            3'b101:  return c_alu_srl;
            3'b110:  return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

    logic [31:0] w_ins;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b;
    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_ok;
    logic        w_br;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    logic        w_legal;
    entry_t      w_dec;

    assign w_ins   = bus.in_instr;
    assign w_f3    = w_ins[14:12];
    assign w_f7    = w_ins[31:25];
    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};

    always_comb begin
        w_op      = c_alu_add;
        w_a       = '0;
        w_b       = '0;
        w_ok      = 1'b0;
        w_br      = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (w_ins[6:0])
            c_opc_op: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_a       = bus.rs1_data;
                w_b       = bus.rs2_data;
                if (w_f7 == c_f7_zero) begin
                    w_ok = 1'b1;
                    w_op = f3_alu(w_f3);
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b000) begin
                    w_ok = 1'b1;
                    w_op = c_alu_sub;
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b101) begin
                    w_ok = 1'b1;
                    w_op = c_alu_sra;
                end
            end
            c_opc_imm: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_a       = bus.rs1_data;
                if (w_f3 == 3'b001) begin
                    w_b  = {27'b0, w_ins[24:20]};
                    w_op = c_alu_sll;
                    w_ok = (w_f7 == c_f7_zero);
                end else if (w_f3 == 3'b101) begin
                    w_b  = {27'b0, w_ins[24:20]};
                    w_op = (w_f7 == c_f7_alt) ? c_alu_sra : c_alu_srl;
                    w_ok = (w_f7 == c_f7_zero) || (w_f7 == c_f7_alt);
                end else begin
                    w_b  = w_imm_i;
                    w_op = f3_alu(w_f3);
                    w_ok = 1'b1;
                end
            end
            c_opc_lui, c_opc_auipc: begin
                w_use_rd = 1'b1;
                w_ok     = 1'b1;
                w_a      = (w_ins[6:0] == c_opc_auipc) ? bus.in_pc : 32'h0;
                w_b      = w_imm_u;
            end
            c_opc_br: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_br      = 1'b1;
                w_a       = bus.rs1_data;
                w_b       = bus.rs2_data;
                w_ok      = 1'b1;
                case (w_f3)
                    3'b000:  w_op = c_alu_seq;
                    3'b001:  w_op = c_alu_sne;
                    3'b100:  w_op = c_alu_slt;
                    3'b101:  w_op = c_alu_sge;
                    3'b110:  w_op = c_alu_sltu;
                    3'b111:  w_op = c_alu_sgeu;
                    default: w_ok = 1'b0;
                endcase
            end
            default: ;
        endcase

        // RV32E only has x0-x15: bit 4 of any used register field is illegal
        w_legal = w_ok && !(w_use_rs1 && w_ins[19]) && !(w_use_rs2 && w_ins[24])
                       && !(w_use_rd && w_ins[11]);

        w_dec           = '0;
        w_dec.pc        = bus.in_pc;
        w_dec.br_target = bus.in_pc + w_imm_b;
        w_dec.illegal   = !w_legal;
        if (w_legal) begin
            w_dec.alu_op    = w_op;
            w_dec.a         = w_a;
            w_dec.b         = w_b;
            w_dec.is_branch = w_br;
            w_dec.rd        = w_br ? 4'd0 : w_ins[10:7];
            w_dec.we        = !w_br && (w_ins[10:7] != 4'd0);
        end
    end

    entry_t r_m;
    entry_t r_s;
    logic   r_m_valid;
    logic   r_s_valid;
    logic   w_acc;
    logic   w_cons;

    assign w_acc  = bus.in_valid && bus.in_ready;
    assign w_cons = r_m_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m       <= '0;
            r_s       <= '0;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (bus.flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (r_s_valid) begin
            if (w_cons) begin
                r_m       <= r_s;
                r_s_valid <= 1'b0;
            end
        end else if (w_acc) begin
            if (!r_m_valid || w_cons) begin
                r_m       <= w_dec;
                r_m_valid <= 1'b1;
            end else begin
                r_s       <= w_dec;
                r_s_valid <= 1'b1;
            end
        end else if (w_cons) begin
            r_m_valid <= 1'b0;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            assign bus.in_ready = !r_s_valid;
        end else begin : g_single
            assign bus.in_ready = !r_m_valid || bus.out_ready;
        end
    endgenerate

    assign bus.out_valid     = r_m_valid;
    assign bus.out_alu_op    = r_m.alu_op;
    assign bus.out_a         = r_m.a;
    assign bus.out_b         = r_m.b;
    assign bus.out_rd        = r_m.rd;
    assign bus.out_we        = r_m.we;
    assign bus.out_is_branch = r_m.is_branch;
    assign bus.out_br_target = r_m.br_target;
    assign bus.out_pc        = r_m.pc;
    assign bus.out_illegal   = r_m.illegal;
endmodule
`default_nettype wire
